// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer (IF/ID/EX/MEM/WB/HALT); waits in IF/MEM until mem_ready; 3-5 cycles/instr.
// Optional PERF_CNT_EN adds cycle_count/instret counters; outputs forced low while reset is low.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 halt_cond,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 pc_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
`ifdef PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret,
`endif
  output logic                 is_halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_ZERO   = 7'b0000000;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   is_load;

  assign is_load = (opcode == OP_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IF;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IF:   if (mem_ready) next_state = S_ID;
      S_ID:   next_state = S_EX;
      S_EX: begin
        case (opcode)
          OP_R, OP_I:          next_state = S_WB;
          OP_LOAD, OP_STORE:   next_state = S_MEM;
          OP_ECALL, OP_ZERO:   next_state = halt_cond ? S_HALT : S_IF;
          default:             next_state = S_IF;
        endcase
      end
      // Only LOAD and STORE reach MEM, so anything not a load is the store path.
      S_MEM:  if (mem_ready) next_state = is_load ? S_WB : S_IF;
      S_WB:   next_state = S_IF;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (reset) begin
      case (state)
        S_IF: begin
          ctrl.mem_read = 1'b1;
          ctrl.ir_write = mem_ready;
        end
        S_ID: begin
          ctrl.alu_src_b = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        S_EX: begin
          case (opcode)
            OP_R: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_op    = ALU_FUNCT;
            end
            OP_I: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = 1'b1;
              ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = 1'b1;
              ctrl.alu_op    = ALU_ADD;
            end
            OP_BRANCH: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_op    = ALU_CMP;
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_BRANCH;
            end
            OP_JAL: begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_ALUOUT;
              ctrl.reg_write = 1'b1;
              ctrl.pc_to_reg = 1'b1;
            end
            OP_JALR: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = 1'b1;
              ctrl.alu_op    = ALU_ADD;
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_JALR;
              ctrl.reg_write = 1'b1;
              ctrl.pc_to_reg = 1'b1;
            end
            OP_ECALL, OP_ZERO: begin
              ctrl.pc_write  = ~halt_cond;
              ctrl.pc_source = PC_PLUS4;
            end
            default: begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_PLUS4;
            end
          endcase
        end
        S_MEM: begin
          ctrl.i_or_d    = 1'b1;
          ctrl.mem_read  = is_load;
          ctrl.mem_write = ~is_load;
          ctrl.pc_write  = ~is_load & mem_ready;
          ctrl.pc_source = PC_PLUS4;
        end
        S_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = is_load;
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PC_PLUS4;
        end
        S_HALT:  ctrl.is_halted = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_source  = ctrl.pc_source;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_to_reg  = ctrl.pc_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign is_halted  = ctrl.is_halted;

`ifdef PERF_CNT_EN
  // pc_write fires exactly once per retired instruction, so it doubles as the retire strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + 1'b1;
      if (ctrl.pc_write)   instret     <= instret + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule
